// File: rtl/output_stream_writer.sv
// rtl/output_stream_writer.sv - result stream to linear-address memory writer with FIFO
//
// Captures an unhandshaked result stream, buffers {addr, data} entries in a
// small FIFO, and writes them to a result memory. It also counts accepted
// results, signals layer completion, and flags dropped results.
//
// Ports:
//   clk, arst_n_in         clock, asynchronous active-low reset
//   start                  one-cycle pulse; arms collection for one layer
//   running                upstream busy indicator
//   out, output_valid      result word and its valid strobe (no ready)
//   output_x/y/ch          result coordinates
//   mem_write_en/addr, mem_din, mem_ready   memory write handshake
//   done                   layer fully written; held until next start
//   overflow, addr_error   sticky drop flags
//   out_count              results accepted this layer
module output_stream_writer #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int FIFO_DEPTH         = 4,
   parameter int ADDR_WIDTH         = $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS)
) (
   input  logic                                  clk,
   input  logic                                  arst_n_in,
   input  logic                                  start,
   input  logic                                  running,
   input  logic signed [IO_DATA_WIDTH-1:0]       out,
   input  logic                                  output_valid,
   input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
   input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
   output logic                                  mem_write_en,
   output logic [ADDR_WIDTH-1:0]                 mem_write_addr,
   output logic [IO_DATA_WIDTH-1:0]              mem_din,
   input  logic                                  mem_ready,
   output logic                                  done,
   output logic                                  overflow,
   output logic                                  addr_error,
   output logic [ADDR_WIDTH:0]                   out_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

   state_t state, state_next;
   logic   clear;
   logic   seen_running;

   logic [ADDR_WIDTH-1:0]    fifo_addr [FIFO_DEPTH];
   logic [IO_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]         rd_ptr, wr_ptr;
   logic [PTR_W:0]           count;

   logic [ADDR_WIDTH-1:0] addr;
   logic in_range, collecting, at_total, full, pop, push, drop_full, drop_range;

   assign addr = (ADDR_WIDTH'(output_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH) + ADDR_WIDTH'(output_x))
                 * ADDR_WIDTH'(OUTPUT_NB_CHANNELS) + ADDR_WIDTH'(output_ch);

   // Coordinate fields may be wider than the legal range (non power-of-two sizes).
   assign in_range = (int'(output_x) < FEATURE_MAP_WIDTH) &&
                     (int'(output_y) < FEATURE_MAP_HEIGHT) &&
                     (int'(output_ch) < OUTPUT_NB_CHANNELS);

   assign collecting = (state == COLLECT);
   assign at_total   = (out_count == (ADDR_WIDTH+1)'(TOTAL));
   assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));

   assign mem_write_en   = (count != '0) && (state == COLLECT || state == DRAIN);
   assign mem_write_addr = fifo_addr[rd_ptr];
   assign mem_din        = fifo_data[rd_ptr];
   assign pop            = mem_write_en && mem_ready;

   // A full FIFO still accepts when the head leaves in the same cycle. The
   // at_total guard covers the one cycle between the last push and leaving COLLECT.
   assign push       = collecting && output_valid && in_range && !at_total && (!full || pop);
   assign drop_range = collecting && output_valid && !in_range;
   assign drop_full  = output_valid && ((collecting && in_range && !push) || state == DRAIN);

   assign done = (state == DONE);

   always_comb begin
      state_next = state;
      clear      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = COLLECT;
               clear      = 1'b1;
            end
         end
         COLLECT: begin
            if (at_total || (!running && seen_running)) state_next = DRAIN;
         end
         DRAIN: begin
            if (count == '0) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state        <= IDLE;
         seen_running <= 1'b0;
         out_count    <= '0;
         overflow     <= 1'b0;
         addr_error   <= 1'b0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         state <= state_next;
         if (clear) begin
            seen_running <= 1'b0;
            out_count    <= '0;
            overflow     <= 1'b0;
            addr_error   <= 1'b0;
         end else begin
            if (collecting && running) seen_running <= 1'b1;
            if (push) out_count <= out_count + 1'b1;
            if (drop_full) overflow <= 1'b1;
            if (drop_range) addr_error <= 1'b1;
         end
         if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= out;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

endmodule

// File: doc/output_stream_writer.md
# output_stream_writer

Downstream stage of the convolution system. Captures the unhandshaked result stream (`out`, `output_valid`, `output_x/y/ch`) and converts each result into a write to a result memory at a linear address. The block buffers results in a small FIFO to absorb memory back-pressure, counts results, and signals completion. It also flags dropped or out-of-range results, because the upstream stream cannot be stalled.

## Interface

Parameters:
- `IO_DATA_WIDTH`, 16, width of one result word.
- `FEATURE_MAP_WIDTH`, 1024, number of x positions.
- `FEATURE_MAP_HEIGHT`, 1024, number of y positions.
- `OUTPUT_NB_CHANNELS`, 64, number of output channels.
- `FIFO_DEPTH`, 4, number of buffered results; power of two, ≥2.
- `ADDR_WIDTH`, `$clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS)`, width of the result-memory address.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `arst_n_in`  in  1  asynchronous reset, active low.
- `start`  in  1  one-cycle pulse; arms collection for one layer.
- `running`  in  1  upstream busy indicator.
- `out`  in  `IO_DATA_WIDTH`  signed result word.
- `output_valid`  in  1  result present this cycle; no ready signal exists.
- `output_x`  in  `$clog2(FEATURE_MAP_WIDTH)`  result column.
- `output_y`  in  `$clog2(FEATURE_MAP_HEIGHT)`  result row.
- `output_ch`  in  `$clog2(OUTPUT_NB_CHANNELS)`  result channel.
- `mem_write_en`  out  1  write request.
- `mem_write_addr`  out  `ADDR_WIDTH`  write address.
- `mem_din`  out  `IO_DATA_WIDTH`  write data.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `done`  out  1  layer fully written; held until next `start`.
- `overflow`  out  1  sticky: a result was dropped.
- `addr_error`  out  1  sticky: a result with out-of-range coordinates was dropped.
- `out_count`  out  `ADDR_WIDTH+1`  number of results accepted this layer.

## Operation

- **Address:** `addr = (output_y*FEATURE_MAP_WIDTH + output_x)*OUTPUT_NB_CHANNELS + output_ch`. Computed at full `ADDR_WIDTH` with no truncation. `TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS`.
- **FIFO:** entries are `{addr, out}`. Storage is registered; the head drives `mem_write_addr`/`mem_din` directly.
- **Write handshake:**
  - `mem_write_en` = FIFO not empty and state ∈ {COLLECT, DRAIN}.
  - Pop occurs when `mem_write_en && mem_ready`.
  - Head address and data are stable while `mem_write_en=1` and `mem_ready=0`.
- **State machine:**
  - IDLE: `output_valid` is ignored; no flags change. `start` → COLLECT, clearing `out_count`, `overflow`, `addr_error`, and the seen-running latch.
  - COLLECT: `running=1` sets the seen-running latch. Go to DRAIN when `out_count` reaches `TOTAL`, or when `running=0` with the latch set.
  - DRAIN: wait until the FIFO is empty → DONE. Any `output_valid` in DRAIN is dropped and sets `overflow`.
  - DONE: `done=1`. `start` → COLLECT (same clears as from IDLE). `output_valid` is ignored.
- **Push rule (COLLECT, `output_valid=1`):**
  - If any coordinate is out of range (`x≥FEATURE_MAP_WIDTH`, `y≥FEATURE_MAP_HEIGHT`, `ch≥OUTPUT_NB_CHANNELS`): drop and set `addr_error`.
  - Else, if FIFO occupancy < `FIFO_DEPTH` or a pop occurs the same cycle: push and increment `out_count`.
  - Else: drop and set `overflow`.
- **Boundary rules:**
  - Simultaneous push and pop on a full FIFO: both happen; occupancy is unchanged.
  - Simultaneous push and pop on an empty FIFO: no pop exists, so only the push happens.
  - FIFO pointers wrap modulo `FIFO_DEPTH`.
  - `out_count` never exceeds `TOTAL`, because the block leaves COLLECT on reaching it.
  - `start` outside IDLE/DONE is ignored.
- **Reset mid-operation:** FIFO contents are discarded and the state returns to IDLE immediately.

## Timing

- **Reset values:** `mem_write_en=0`, `mem_write_addr=0`, `mem_din=0`, `done=0`, `overflow=0`, `addr_error=0`, `out_count=0`; state IDLE, FIFO empty.
- **Latency:** a result accepted at cycle t into an empty FIFO gives `mem_write_en=1` at t+1, with its address and data.
- **Throughput:** one write per cycle while `mem_ready=1`.
- **Counter:** `out_count` updates the cycle after the push.
- **State change:** the COLLECT→DRAIN decision uses the value of `out_count` registered that cycle; the state changes at the next edge.
- **Completion:** `done` rises the cycle after the FIFO becomes empty in DRAIN, and falls the cycle after `start` is sampled in DONE.
- **Flags:** `overflow` and `addr_error` rise the cycle after the offending sample.

## Test plan

Bench parameters unless stated: W=4, H=2, C=2, `TOTAL=16`, `FIFO_DEPTH=4`.

- **Full layer, no back-pressure:** reset, `start`, `running=1`; 16 results, one per cycle, in raster order, with `out=addr`; `mem_ready=1`. Expect 16 writes with `addr` = 0..15 and `mem_din=addr`, each one cycle after its result; then `done=1`; `overflow=0`.
- **Address formula:** single result with x=3, y=1, ch=1, `out=-5`. Expect `mem_write_addr=15`, `mem_din=16'hFFFB`.
- **Back-pressure and overflow:** `mem_ready=0`; send 5 results on consecutive cycles. Expect the first 4 buffered, the 5th dropped, `overflow=1`, `out_count=4`. Then raise `mem_ready`: expect 4 writes in order, with data stable while stalled.
- **Full FIFO, simultaneous push/pop:** FIFO full, `mem_ready=1`, `output_valid=1`. Expect the result accepted, `overflow` unchanged at 0, occupancy still 4.
- **Out-of-range coordinates:** with `FEATURE_MAP_WIDTH=3`, send x=3. Expect no write, `addr_error=1`, `out_count` unchanged.
- **Early stop and reset mid-operation:** `running` falls after 6 results. Expect DRAIN, 6 writes, `done=1`, `out_count=6`. Separately, assert `arst_n_in=0` with 3 entries queued: expect `mem_write_en=0` immediately and all outputs at reset values.
